pll_lock_ctrl: RTL and testbench

Supervisor and sequencer for the core's main PLL, clocked by the PLL reference clock. It pulses the PLL reset, waits for `locked` under a timeout and retries a bounded number of times. It qualifies lock as stable before releasing the core-wide reset, and re-runs the whole sequence on loss of lock or on a soft request such as the OSD reset. It sits between the PLL wrapper and the core reset tree, so the core only leaves reset on clean, stable clocks.

---
 rtl/pll_ctrl_pkg.sv | 33 +++
 rtl/pll_lock_sync.sv | 32 +++
 rtl/pll_lock_ctrl.sv | 147 ++++++++++++++
 tb/tb_pll_lock_ctrl.sv | 143 ++++++++++++++
 4 files changed

// File: rtl/pll_ctrl_pkg.sv
// Shared types and width helpers for the PLL lock supervisor.
package pll_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAIL      = 3'd4
    } pll_ctrl_state_t;

    // Smallest width w with 2**w >= value, never below 1.
    function automatic int clog2_min1(input int unsigned value);
        int w;
        w = 0;
        for (int i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(value)) begin
                w = i + 1;
            end
        end
        return (w < 1) ? 1 : w;
    endfunction

    function automatic int unsigned max3(input int unsigned a, input int unsigned b,
                                         input int unsigned c);
        int unsigned m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/pll_lock_sync.sv
// Multi-flop synchroniser bringing the PLL lock flag into the refclk domain.
module pll_lock_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic refclk,
    input  logic rst_n,
    input  logic locked_i,
    output logic lk
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic [SYNC_STAGES-1:0] w_sync_d;

    assign w_sync_d = {r_sync[SYNC_STAGES-2:0], locked_i};

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_stage
            // One synchroniser flop; cleared asynchronously so lock never looks stale.
            always_ff @(posedge refclk or negedge rst_n) begin
                if (!rst_n) begin
                    r_sync[gi] <= 1'b0;
                end else begin
                    r_sync[gi] <= w_sync_d[gi];
                end
            end
        end
    endgenerate

    assign lk = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/pll_lock_ctrl.sv
// PLL supervisor: pulses PLL reset, waits for lock with timeout and bounded
// retries, qualifies lock as stable, then releases the core reset.
module pll_lock_ctrl
    import pll_ctrl_pkg::*;
#(
    parameter int HOLD_CYCLES   = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int SYNC_STAGES   = 2,
    parameter int MAX_RETRY     = 3
) (
    input  logic                                  refclk,
    input  logic                                  rst_n,
    input  logic                                  locked_i,
    input  logic                                  req_reset,
    output logic                                  pll_rst,
    output logic                                  sys_reset,
    output logic                                  ready,
    output logic                                  fail,
    output logic [clog2_min1(MAX_RETRY+1)-1:0]    retries
);

    localparam int RW    = clog2_min1(MAX_RETRY + 1);
    localparam int CNT_W = clog2_min1(max3(HOLD_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES));

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(STABLE_CYCLES - 1);
    localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRY);

    pll_ctrl_state_t  r_state;
    pll_ctrl_state_t  w_state_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_next;
    logic [RW-1:0]    r_retries;
    logic [RW-1:0]    w_retries_next;
    logic             r_pll_rst;
    logic             r_sys_reset;
    logic             r_ready;
    logic             r_fail;
    logic             w_lk;

    pll_lock_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .refclk   (refclk),
        .rst_n    (rst_n),
        .locked_i (locked_i),
        .lk       (w_lk)
    );

    // Next-state, retry bookkeeping and shared-counter decode.
    always_comb begin
        w_state_next   = r_state;
        w_retries_next = r_retries;
        if (req_reset) begin
            w_state_next   = ST_RESET_PLL;
            w_retries_next = '0;
        end else begin
            case (r_state)
                ST_RESET_PLL: begin
                    if (r_cnt == HOLD_LAST) begin
                        w_state_next = ST_WAIT_LOCK;
                    end
                end
                ST_WAIT_LOCK: begin
                    // Lock wins over a coincident timeout.
                    if (w_lk) begin
                        w_state_next = ST_STABILIZE;
                    end else if (r_cnt == TIMEOUT_LAST) begin
                        if (r_retries == RETRY_LIMIT) begin
                            w_state_next = ST_FAIL;
                        end else begin
                            w_retries_next = r_retries + 1'b1;
                            w_state_next   = ST_RESET_PLL;
                        end
                    end
                end
                ST_STABILIZE: begin
                    // A lock drop while qualifying is treated as a failed attempt.
                    if (!w_lk) begin
                        if (r_retries == RETRY_LIMIT) begin
                            w_state_next = ST_FAIL;
                        end else begin
                            w_retries_next = r_retries + 1'b1;
                            w_state_next   = ST_RESET_PLL;
                        end
                    end else if (r_cnt == STABLE_LAST) begin
                        w_state_next = ST_RUN;
                    end
                end
                ST_RUN: begin
                    // Loss of lock after a good run is a fresh incident.
                    if (!w_lk) begin
                        w_retries_next = '0;
                        w_state_next   = ST_RESET_PLL;
                    end
                end
                ST_FAIL: begin
                    w_state_next = ST_FAIL;
                end
                default: begin
                    w_state_next = ST_RESET_PLL;
                end
            endcase
        end

        // Counter restarts on any state change or restart request; it only
        // runs in the timed states, so it never needs to wrap.
        if (req_reset || (w_state_next != r_state)) begin
            w_cnt_next = '0;
        end else if ((r_state == ST_RESET_PLL) || (r_state == ST_WAIT_LOCK) ||
                     (r_state == ST_STABILIZE)) begin
            w_cnt_next = r_cnt + 1'b1;
        end else begin
            w_cnt_next = r_cnt;
        end
    end

    // State, counter, retries and outputs registered together from the next state.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_RESET_PLL;
            r_cnt       <= '0;
            r_retries   <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_reset <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_cnt       <= w_cnt_next;
            r_retries   <= w_retries_next;
            r_pll_rst   <= (w_state_next == ST_RESET_PLL);
            r_sys_reset <= (w_state_next != ST_RUN);
            r_ready     <= (w_state_next == ST_RUN);
            r_fail      <= (w_state_next == ST_FAIL);
        end
    end

    assign pll_rst   = r_pll_rst;
    assign sys_reset = r_sys_reset;
    assign ready     = r_ready;
    assign fail      = r_fail;
    assign retries   = r_retries;

endmodule

// File: tb/tb_pll_lock_ctrl.sv
// Directed bench for pll_lock_ctrl with small timing parameters.
module tb_pll_lock_ctrl;

    logic       refclk;
    logic       rst_n;
    logic       locked_i;
    logic       req_reset;
    logic       pll_rst;
    logic       sys_reset;
    logic       ready;
    logic       fail;
    logic [1:0] retries;

    int n_checks;
    int n_errors;
    int ecnt;

    // Observed output bundle: {pll_rst, sys_reset, ready, fail, retries[1:0]}
    wire [5:0] w_obs = {pll_rst, sys_reset, ready, fail, retries};

    pll_lock_ctrl #(
        .HOLD_CYCLES   (4),
        .LOCK_TIMEOUT  (20),
        .STABLE_CYCLES (8),
        .SYNC_STAGES   (2),
        .MAX_RETRY     (2)
    ) dut (
        .refclk    (refclk),
        .rst_n     (rst_n),
        .locked_i  (locked_i),
        .req_reset (req_reset),
        .pll_rst   (pll_rst),
        .sys_reset (sys_reset),
        .ready     (ready),
        .fail      (fail),
        .retries   (retries)
    );

    initial refclk = 1'b0;
    always #5 refclk = ~refclk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%b exp=%b (edge %0d)", tag, got, exp, ecnt);
        end else begin
            $display("ok   %s val=%b (edge %0d)", tag, got, ecnt);
        end
    endtask

    // Advance to 1 time unit after rising edge k (counted from reset release).
    task automatic goto(input int k);
        while (ecnt < k) begin
            @(posedge refclk);
            ecnt++;
        end
        #1;
    endtask

    // Assert reset, check reset values, then release just after "edge 0".
    task automatic do_reset(input logic lock_val);
        req_reset = 1'b0;
        locked_i  = lock_val;
        rst_n     = 1'b0;
        #1;
        chk("reset_vals", 8'(w_obs), 8'b110000);
        repeat (3) @(posedge refclk);
        #2;
        rst_n = 1'b1;
        ecnt  = 0;
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        ecnt      = 0;
        rst_n     = 1'b1;
        locked_i  = 1'b0;
        req_reset = 1'b0;
        #3;

        // Normal bring-up, then loss of lock in RUN
        do_reset(1'b0);
        goto(3);  chk("bringup_pllrst_e3", 8'(pll_rst), 8'd1);
        goto(4);  chk("bringup_wait_e4", 8'(w_obs), 8'b010000);
        goto(10); locked_i = 1'b1;
        goto(20); chk("bringup_notready_e20", 8'(w_obs), 8'b010000);
        goto(21); chk("bringup_run_e21", 8'(w_obs), 8'b001000);
        goto(25); locked_i = 1'b0;
        goto(27); chk("loss_still_run_e27", 8'(w_obs), 8'b001000);
        goto(28); chk("loss_reset_e28", 8'(w_obs), 8'b110000);
        locked_i = 1'b1;
        goto(31); chk("loss_pllrst_e31", 8'(pll_rst), 8'd1);
        goto(32); chk("loss_wait_e32", 8'(w_obs), 8'b010000);
        goto(40); chk("loss_notready_e40", 8'(ready), 8'd0);
        goto(41); chk("loss_rerun_e41", 8'(w_obs), 8'b001000);

        // Glitch during STABILIZE
        do_reset(1'b1);
        goto(5);  chk("glitch_stab_e5", 8'(w_obs), 8'b010000);
        goto(7);  locked_i = 1'b0;
        goto(9);  chk("glitch_pre_e9", 8'(w_obs), 8'b010000);
        goto(10); chk("glitch_retry_e10", 8'(w_obs), 8'b110001);
        locked_i = 1'b1;
        goto(11); chk("glitch_noready_e11", 8'(ready), 8'd0);
        goto(13); chk("glitch_pllrst_e13", 8'(pll_rst), 8'd1);
        goto(14); chk("glitch_wait_e14", 8'(w_obs), 8'b010001);
        goto(22); chk("glitch_notready_e22", 8'(ready), 8'd0);
        goto(23); chk("glitch_run_e23", 8'(w_obs), 8'b001001);

        // Exhausted retries
        do_reset(1'b0);
        goto(23); chk("exh_try0_end_e23", 8'(w_obs), 8'b010000);
        goto(24); chk("exh_retry1_e24", 8'(w_obs), 8'b110001);
        goto(27); chk("exh_pllrst_e27", 8'(pll_rst), 8'd1);
        goto(28); chk("exh_wait_e28", 8'(pll_rst), 8'd0);
        goto(48); chk("exh_retry2_e48", 8'(w_obs), 8'b110010);
        goto(52); chk("exh_wait_e52", 8'(pll_rst), 8'd0);
        goto(71); chk("exh_nofail_e71", 8'(fail), 8'd0);
        goto(72); chk("exh_fail_e72", 8'(w_obs), 8'b010110);
        goto(82); chk("exh_static_e82", 8'(w_obs), 8'b010110);

        // Recovery from FAIL via req_reset, then async reset mid-STABILIZE
        req_reset = 1'b1;
        goto(83); chk("rec_req_e83", 8'(w_obs), 8'b110000);
        req_reset = 1'b0;
        locked_i  = 1'b1;
        goto(86); chk("rec_pllrst_e86", 8'(pll_rst), 8'd1);
        goto(87); chk("rec_wait_e87", 8'(w_obs), 8'b010000);
        goto(90); chk("rec_stab_e90", 8'(w_obs), 8'b010000);
        #1;
        rst_n = 1'b0;
        #1;
        chk("async_rst_noclk", 8'(w_obs), 8'b110000);
        #1;
        rst_n = 1'b1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
